// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised RAM responder with a two-cycle ERROR response.
// Define AHB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states on every NONSEQ data phase.
module ahb_lite_mem_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    localparam int          AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
    localparam logic [2:0] ST_ERR1 = 3'd2;
    localparam logic [2:0] ST_ERR2 = 3'd3;
`ifdef AHB_SLAVE_WAIT_EN
    localparam logic [2:0] ST_WAIT = 3'd4;
`endif

    logic [31:0]   mem [0:MEM_WORDS-1];
    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic          accept;
    logic          acc_err;
    logic [3:0]    lane_en;
    logic [AW-1:0] word_idx;
    logic          unused_ok;

`ifdef AHB_SLAVE_WAIT_EN
    logic [2:0]    wait_cnt;
    assign HREADYOUT = (state != ST_ERR1) && (state != ST_WAIT);
    assign unused_ok = ^HBURST;
`else
    assign HREADYOUT = (state != ST_ERR1);
    assign unused_ok = ^{HBURST, 3'(WAIT_CYCLES)};
`endif

    assign HRESP    = (state == ST_ERR1) || (state == ST_ERR2);
    assign accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign word_idx = addr_q[AW+1:2];

    // Alignment, size and range are judged on the live address phase so no RAM access is ever started for a bad request.
    always_comb begin
        acc_err = 1'b0;
        if (HSIZE > 3'd2) begin
            acc_err = 1'b1;
        end else if ((HSIZE == 3'd1) && HADDR[0]) begin
            acc_err = 1'b1;
        end else if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end
        if (HADDR >= BYTE_LIMIT) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_next = ST_DATA;
                end
            end
`endif
            default: begin
                if (accept) begin
                    if (acc_err) begin
                        state_next = ST_ERR1;
`ifdef AHB_SLAVE_WAIT_EN
                    end else if (HTRANS == 2'b10) begin
                        state_next = ST_WAIT;
`endif
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= HADDR[AW+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
            end
        end
    end

`ifdef AHB_SLAVE_WAIT_EN
    // Loaded with one less than the wait count so WAIT lasts exactly WAIT_CYCLES cycles.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= 3'd0;
        end else if ((state_next == ST_WAIT) && (state != ST_WAIT)) begin
            wait_cnt <= 3'(WAIT_CYCLES - 1);
        end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end
`endif

    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            2'd0:    lane_en[addr_q[1:0]] = 1'b1;
            2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // A reset during the data phase drops state to IDLE asynchronously, which is what discards the pending write.
    always_ff @(posedge HCLK) begin
        if ((state == ST_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if ((state == ST_DATA) && !write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    HRDATA[8*b +: 8] = mem[word_idx][8*b +: 8];
                end
            end
        end
    end
endmodule
